seg_scan_reader: RTL and testbench

- Reads the multiplexed 7-segment drive bus (seg_data1, seg_data2, seg_which) that the clock display drivers produce on the EGo1 board.
- Rebuilds the eight displayed digit values, their decimal points and per-digit valid flags.
- Lets on-chip logic and benches read back what is shown, without probing the pins.
- Sits beside the display driver, on the same 100 MHz clock.

---
 rtl/seg_scan_pkg.sv | 119 +++++++++++
 rtl/seg_group_capture.sv | 89 ++++++++
 rtl/seg_scan_reader.sv | 135 +++++++++++++
 tb/tb_seg_scan_reader.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared segment constants and pattern decode for the 7-segment scan reader.
// Build option: SEG_HEX_DECODE_EN enables A-F decoding.
package seg_scan_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [6:0] S_A = 7'b000_0001 << SEG_A;
  localparam logic [6:0] S_B = 7'b000_0001 << SEG_B;
  localparam logic [6:0] S_C = 7'b000_0001 << SEG_C;
  localparam logic [6:0] S_D = 7'b000_0001 << SEG_D;
  localparam logic [6:0] S_E = 7'b000_0001 << SEG_E;
  localparam logic [6:0] S_F = 7'b000_0001 << SEG_F;
  localparam logic [6:0] S_G = 7'b000_0001 << SEG_G;

  localparam logic [6:0] PAT_0     = S_A | S_B | S_C | S_D | S_E | S_F;
  localparam logic [6:0] PAT_1     = S_B | S_C;
  localparam logic [6:0] PAT_2     = S_A | S_B | S_D | S_E | S_G;
  localparam logic [6:0] PAT_3     = S_A | S_B | S_C | S_D | S_G;
  localparam logic [6:0] PAT_4     = S_B | S_C | S_F | S_G;
  localparam logic [6:0] PAT_5     = S_A | S_C | S_D | S_F | S_G;
  localparam logic [6:0] PAT_6     = S_A | S_C | S_D | S_E | S_F | S_G;
  localparam logic [6:0] PAT_7     = S_A | S_B | S_C;
  localparam logic [6:0] PAT_8     = S_A | S_B | S_C | S_D | S_E | S_F | S_G;
  localparam logic [6:0] PAT_9     = S_A | S_B | S_C | S_D | S_F | S_G;
  localparam logic [6:0] PAT_A     = S_A | S_B | S_C | S_E | S_F | S_G;
  localparam logic [6:0] PAT_B     = S_C | S_D | S_E | S_F | S_G;
  localparam logic [6:0] PAT_C     = S_A | S_D | S_E | S_F;
  localparam logic [6:0] PAT_D     = S_B | S_C | S_D | S_E | S_G;
  localparam logic [6:0] PAT_E     = S_A | S_D | S_E | S_F | S_G;
  localparam logic [6:0] PAT_F     = S_A | S_E | S_F | S_G;
  localparam logic [6:0] PAT_BLANK = 7'h00;

`ifdef SEG_HEX_DECODE_EN
  localparam logic HEX_EN = 1'b1;
`else
  localparam logic HEX_EN = 1'b0;
`endif

  typedef struct packed {
    logic       valid;
    logic       err;
    logic [3:0] code;
  } seg_dec_t;

  function automatic seg_dec_t dec_num(input logic [3:0] code);
    seg_dec_t d;
    d.valid = 1'b1;
    d.err   = 1'b0;
    d.code  = code;
    return d;
  endfunction

  function automatic seg_dec_t dec_bad();
    seg_dec_t d;
    d.valid = 1'b0;
    d.err   = 1'b1;
    d.code  = 4'h0;
    return d;
  endfunction

  function automatic seg_dec_t dec_hex(input logic [3:0] code);
    seg_dec_t d;
    if (HEX_EN) d = dec_num(code);
    else        d = dec_bad();
    return d;
  endfunction

  function automatic seg_dec_t seg_decode(input logic [6:0] pat);
    seg_dec_t d;
    case (pat)
      PAT_0:     d = dec_num(4'h0);
      PAT_1:     d = dec_num(4'h1);
      PAT_2:     d = dec_num(4'h2);
      PAT_3:     d = dec_num(4'h3);
      PAT_4:     d = dec_num(4'h4);
      PAT_5:     d = dec_num(4'h5);
      PAT_6:     d = dec_num(4'h6);
      PAT_7:     d = dec_num(4'h7);
      PAT_8:     d = dec_num(4'h8);
      PAT_9:     d = dec_num(4'h9);
      PAT_A:     d = dec_hex(4'hA);
      PAT_B:     d = dec_hex(4'hB);
      PAT_C:     d = dec_hex(4'hC);
      PAT_D:     d = dec_hex(4'hD);
      PAT_E:     d = dec_hex(4'hE);
      PAT_F:     d = dec_hex(4'hF);
      PAT_BLANK: begin
        d       = dec_bad();
        d.err   = 1'b0;
      end
      default:   d = dec_bad();
    endcase
    return d;
  endfunction

  function automatic logic is_onehot4(input logic [3:0] sel);
    return (sel != 4'h0) && ((sel & (sel - 4'h1)) == 4'h0);
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [3:0] sel);
    logic [1:0] idx;
    case (sel)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/seg_group_capture.sv
// One 4-digit group: select check, settle counter, pattern decode and capture strobe.
// Decode set follows SEG_HEX_DECODE_EN through seg_scan_pkg.
module seg_group_capture
  import seg_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sel,
  input  logic [7:0] pat,
  output logic       cap_stb,
  output logic [1:0] cap_idx,
  output logic [3:0] cap_code,
  output logic       cap_valid,
  output logic       cap_dp,
  output logic       cap_err
);

  localparam int CW = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [CW-1:0] SETTLE_MAX = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_next_s;
  logic [9:0]    prev_r;
  logic          onehot_s;
  logic [1:0]    idx_s;
  logic          same_s;
  logic          fire_s;
  seg_dec_t      dec_s;

  logic          cap_stb_r;
  logic [1:0]    cap_idx_r;
  logic [3:0]    cap_code_r;
  logic          cap_valid_r;
  logic          cap_dp_r;
  logic          cap_err_r;

  // Settle tracking: a zero count marks the previous sample as idle, so it never matches.
  always_comb begin
    onehot_s = is_onehot4(sel);
    idx_s    = onehot_idx(sel);
    same_s   = (cnt_r != {CW{1'b0}}) && ({idx_s, pat} == prev_r);
    dec_s    = seg_decode(pat[SEG_G:SEG_A]);
    if (!onehot_s) begin
      cnt_next_s = {CW{1'b0}};
    end else if (same_s) begin
      if (cnt_r == SETTLE_MAX) cnt_next_s = cnt_r;
      else                     cnt_next_s = cnt_r + CNT_ONE;
    end else begin
      cnt_next_s = CNT_ONE;
    end
    fire_s = onehot_s && (cnt_next_s == SETTLE_MAX) && !(same_s && (cnt_r == SETTLE_MAX));
  end

  // Counter, last sample and registered capture outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r       <= {CW{1'b0}};
      prev_r      <= 10'h000;
      cap_stb_r   <= 1'b0;
      cap_idx_r   <= 2'd0;
      cap_code_r  <= 4'h0;
      cap_valid_r <= 1'b0;
      cap_dp_r    <= 1'b0;
      cap_err_r   <= 1'b0;
    end else begin
      cnt_r     <= cnt_next_s;
      prev_r    <= {idx_s, pat};
      cap_stb_r <= fire_s;
      cap_err_r <= fire_s && dec_s.err;
      if (fire_s) begin
        cap_idx_r   <= idx_s;
        cap_code_r  <= dec_s.code;
        cap_valid_r <= dec_s.valid;
        cap_dp_r    <= pat[SEG_DP];
      end
    end
  end

  assign cap_stb   = cap_stb_r;
  assign cap_idx   = cap_idx_r;
  assign cap_code  = cap_code_r;
  assign cap_valid = cap_valid_r;
  assign cap_dp    = cap_dp_r;
  assign cap_err   = cap_err_r;

endmodule

// File: rtl/seg_scan_reader.sv
// Rebuilds the eight displayed digits from the multiplexed 7-segment drive bus.
// Build option: SEG_HEX_DECODE_EN enables A-F decoding.
module seg_scan_reader
  import seg_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  seg_data1,
  input  logic [7:0]  seg_data2,
  input  logic [7:0]  seg_which,
  output logic [31:0] digits,
  output logic [7:0]  dp,
  output logic [7:0]  digit_valid,
  output logic        frame_done,
  output logic        decode_err,
  output logic        stale
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_ONE = TW'(1);

  logic [23:0]   sync1_r;
  logic [23:0]   sync2_r;

  logic          lo_stb_s, hi_stb_s;
  logic [1:0]    lo_idx_s, hi_idx_s;
  logic [3:0]    lo_code_s, hi_code_s;
  logic          lo_valid_s, hi_valid_s;
  logic          lo_dp_s, hi_dp_s;
  logic          lo_err_s, hi_err_s;

  logic [7:0]    cap_bits_s;
  logic [7:0]    mask_next_s;
  logic          any_cap_s;
  logic [TW-1:0] to_next_s;
  logic          going_stale_s;

  logic [31:0]   digits_r;
  logic [7:0]    dp_r;
  logic [7:0]    valid_r;
  logic [7:0]    mask_r;
  logic          frame_done_r;
  logic          decode_err_r;
  logic [TW-1:0] to_r;
  logic          stale_r;

  // Two-flop synchroniser on the whole bus: {which, data2, data1}.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 24'h000000;
      sync2_r <= 24'h000000;
    end else begin
      sync1_r <= {seg_which, seg_data2, seg_data1};
      sync2_r <= sync1_r;
    end
  end

  seg_group_capture #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_lo (
    .clk(clk), .rst(rst),
    .sel(sync2_r[19:16]), .pat(sync2_r[7:0]),
    .cap_stb(lo_stb_s), .cap_idx(lo_idx_s), .cap_code(lo_code_s),
    .cap_valid(lo_valid_s), .cap_dp(lo_dp_s), .cap_err(lo_err_s)
  );

  seg_group_capture #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_hi (
    .clk(clk), .rst(rst),
    .sel(sync2_r[23:20]), .pat(sync2_r[15:8]),
    .cap_stb(hi_stb_s), .cap_idx(hi_idx_s), .cap_code(hi_code_s),
    .cap_valid(hi_valid_s), .cap_dp(hi_dp_s), .cap_err(hi_err_s)
  );

  // Capture mask and timeout next-state.
  always_comb begin
    cap_bits_s = 8'h00;
    if (lo_stb_s) cap_bits_s[{1'b0, lo_idx_s}] = 1'b1;
    else          cap_bits_s = cap_bits_s;
    if (hi_stb_s) cap_bits_s[{1'b1, hi_idx_s}] = 1'b1;
    else          cap_bits_s = cap_bits_s;
    mask_next_s = mask_r | cap_bits_s;
    any_cap_s   = lo_stb_s | hi_stb_s;
    if (any_cap_s)           to_next_s = {TW{1'b0}};
    else if (to_r == TO_MAX) to_next_s = to_r;
    else                     to_next_s = to_r + TO_ONE;
    going_stale_s = (to_next_s == TO_MAX);
  end

  // Digit registers, frame tracking and staleness.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_r     <= 32'h0000_0000;
      dp_r         <= 8'h00;
      valid_r      <= 8'h00;
      mask_r       <= 8'h00;
      frame_done_r <= 1'b0;
      decode_err_r <= 1'b0;
      to_r         <= {TW{1'b0}};
      stale_r      <= 1'b0;
    end else begin
      if (going_stale_s) valid_r <= 8'h00;
      if (lo_stb_s) begin
        digits_r[{1'b0, lo_idx_s, 2'b00} +: 4] <= lo_code_s;
        dp_r[{1'b0, lo_idx_s}]                 <= lo_dp_s;
        valid_r[{1'b0, lo_idx_s}]              <= lo_valid_s;
      end
      if (hi_stb_s) begin
        digits_r[{1'b1, hi_idx_s, 2'b00} +: 4] <= hi_code_s;
        dp_r[{1'b1, hi_idx_s}]                 <= hi_dp_s;
        valid_r[{1'b1, hi_idx_s}]              <= hi_valid_s;
      end
      // A completing frame drops this cycle's captures rather than seeding the next frame.
      if (mask_next_s == 8'hFF) begin
        frame_done_r <= 1'b1;
        mask_r       <= 8'h00;
      end else begin
        frame_done_r <= 1'b0;
        mask_r       <= mask_next_s;
      end
      decode_err_r <= (lo_stb_s & lo_err_s) | (hi_stb_s & hi_err_s);
      to_r         <= to_next_s;
      stale_r      <= going_stale_s;
    end
  end

  assign digits      = digits_r;
  assign dp          = dp_r;
  assign digit_valid = valid_r;
  assign frame_done  = frame_done_r;
  assign decode_err  = decode_err_r;
  assign stale       = stale_r;

endmodule

// File: tb/tb_seg_scan_reader.sv
// Directed bench for seg_scan_reader (SETTLE_CYCLES=4, TIMEOUT_CYCLES=100).
// Expected A-F behaviour follows SEG_HEX_DECODE_EN.
module tb_seg_scan_reader;

  logic        clk;
  logic        rst;
  logic [7:0]  seg_data1;
  logic [7:0]  seg_data2;
  logic [7:0]  seg_which;
  logic [31:0] digits;
  logic [7:0]  dp;
  logic [7:0]  digit_valid;
  logic        frame_done;
  logic        decode_err;
  logic        stale;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  int err_cnt = 0;

  localparam logic [31:0] LO_PATS = 32'h4F5B063F; // byte k = digit k ('0'..'3')
  localparam logic [31:0] HI_PATS = 32'h077D6D66; // byte k = digit k+4 ('4'..'7')

  seg_scan_reader #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst),
    .seg_data1(seg_data1), .seg_data2(seg_data2), .seg_which(seg_which),
    .digits(digits), .dp(dp), .digit_valid(digit_valid),
    .frame_done(frame_done), .decode_err(decode_err), .stale(stale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (decode_err === 1'b1) err_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [7:0] w, input logic [7:0] d1, input logic [7:0] d2, input int n);
    seg_which = w;
    seg_data1 = d1;
    seg_data2 = d2;
    repeat (n) step();
  endtask

  task automatic scan_pos(input int k, input int n);
    logic [3:0] oh;
    logic [31:0] lo;
    logic [31:0] hi;
    oh = 4'b0001 << k;
    lo = LO_PATS;
    hi = HI_PATS;
    apply({oh, oh}, lo[8*k +: 8], hi[8*k +: 8], n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    seg_which = 8'h00; seg_data1 = 8'h00; seg_data2 = 8'h00;
    repeat (3) step();
    checks++; if ({digits, dp, digit_valid} !== 48'h0) begin errors++; $display("FAIL reset_regs got %h exp 0", {digits, dp, digit_valid}); end
    checks++; if ({frame_done, decode_err, stale} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {frame_done, decode_err, stale}); end
    rst = 1'b0;
    repeat (3) step();
    checks++; if ({digits, digit_valid, stale} !== 41'h0) begin errors++; $display("FAIL post_reset got %h exp 0", {digits, digit_valid, stale}); end
  endtask

  task automatic test_scan_frame();
    int fd0, e0;
    fd0 = fd_cnt; e0 = err_cnt;
    for (int k = 0; k < 4; k++) scan_pos(k, 20);
    apply(8'h00, 8'h00, 8'h00, 5);
    checks++; if (digits !== 32'h76543210) begin errors++; $display("FAIL scan_digits got %h exp 76543210", digits); end
    checks++; if (digit_valid !== 8'hFF) begin errors++; $display("FAIL scan_valid got %h exp ff", digit_valid); end
    checks++; if (dp !== 8'h00) begin errors++; $display("FAIL scan_dp got %h exp 00", dp); end
    checks++; if (fd_cnt - fd0 !== 1) begin errors++; $display("FAIL scan_frame_done got %0d exp 1", fd_cnt - fd0); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL scan_no_err got %0d exp 0", err_cnt - e0); end
  endtask

  task automatic test_settle();
    for (int i = 0; i < 5; i++) begin
      apply(8'h01, 8'h6D, 8'h00, 2);
      apply(8'h01, 8'h06, 8'h00, 2);
    end
    checks++; if (digits !== 32'h76543210) begin errors++; $display("FAIL toggle_no_capture got %h exp 76543210", digits); end
    apply(8'h01, 8'h6D, 8'h00, 6);
    checks++; if (digits[3:0] !== 4'h0) begin errors++; $display("FAIL settle_early got %h exp 0", digits[3:0]); end
    step();
    checks++; if (digits[3:0] !== 4'h5) begin errors++; $display("FAIL settle_capture got %h exp 5", digits[3:0]); end
    repeat (3) step();
  endtask

  task automatic test_dp_err();
    int e0;
    e0 = err_cnt;
    apply(8'h20, 8'h00, 8'hED, 12);
    checks++; if ({digits[23:20], dp[5], digit_valid[5]} !== 6'b0101_1_1) begin errors++; $display("FAIL dp_capture got %b exp 010111", {digits[23:20], dp[5], digit_valid[5]}); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL dp_no_err got %0d exp 0", err_cnt - e0); end
    apply(8'h20, 8'h00, 8'h49, 12);
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL bad_err_pulse got %0d exp 1", err_cnt - e0); end
    checks++; if ({digits[23:20], dp[5], digit_valid[5]} !== 6'b0000_0_0) begin errors++; $display("FAIL bad_digit got %b exp 000000", {digits[23:20], dp[5], digit_valid[5]}); end
  endtask

  task automatic test_hex_blank();
    int e0;
    e0 = err_cnt;
    apply(8'h04, 8'h77, 8'h00, 12);
`ifdef SEG_HEX_DECODE_EN
    checks++; if ({digits[11:8], digit_valid[2]} !== 5'b1010_1) begin errors++; $display("FAIL hex_a got %b exp 10101", {digits[11:8], digit_valid[2]}); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL hex_a_err got %0d exp 0", err_cnt - e0); end
`else
    checks++; if ({digits[11:8], digit_valid[2]} !== 5'b0000_0) begin errors++; $display("FAIL hex_a got %b exp 00000", {digits[11:8], digit_valid[2]}); end
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL hex_a_err got %0d exp 1", err_cnt - e0); end
`endif
    e0 = err_cnt;
    apply(8'h08, 8'h00, 8'h00, 12);
    checks++; if ({digits[15:12], digit_valid[3]} !== 5'b0000_0) begin errors++; $display("FAIL blank got %b exp 00000", {digits[15:12], digit_valid[3]}); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL blank_err got %0d exp 0", err_cnt - e0); end
  endtask

  task automatic test_stale();
    logic got;
    got = 1'b0;
    for (int k = 0; k < 3; k++) scan_pos(k, 20);
    scan_pos(3, 0);
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      if (frame_done === 1'b1) got = 1'b1;
    end
    seg_which = 8'h00;
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL stale_frame got %b exp 1", got); end
    repeat (99) step();
    checks++; if ({stale, digit_valid} !== 9'h0FF) begin errors++; $display("FAIL stale_early got %h exp 0ff", {stale, digit_valid}); end
    step();
    checks++; if ({stale, digit_valid} !== 9'h100) begin errors++; $display("FAIL stale_set got %h exp 100", {stale, digit_valid}); end
    checks++; if (digits !== 32'h76543210) begin errors++; $display("FAIL stale_hold got %h exp 76543210", digits); end
    apply(8'h01, 8'h3F, 8'h00, 10);
    checks++; if ({stale, digit_valid} !== 9'h001) begin errors++; $display("FAIL stale_clear got %h exp 001", {stale, digit_valid}); end
  endtask

  task automatic test_reset_mid_frame();
    int fd0;
    scan_pos(0, 20);
    scan_pos(1, 20);
    apply(8'h04, 8'h5B, 8'h00, 20);
    fd0 = fd_cnt;
    rst = 1'b1;
    seg_which = 8'h00;
    #1;
    checks++; if ({digits, dp, digit_valid, frame_done, decode_err, stale} !== 51'h0) begin errors++; $display("FAIL midreset got %h exp 0", {digits, dp, digit_valid, frame_done, decode_err, stale}); end
    repeat (3) step();
    rst = 1'b0;
    step();
    for (int k = 0; k < 3; k++) scan_pos(k, 20);
    apply(8'h08, 8'h4F, 8'h00, 20);
    checks++; if (fd_cnt - fd0 !== 0) begin errors++; $display("FAIL midreset_seven got %0d exp 0", fd_cnt - fd0); end
    apply(8'h80, 8'h00, 8'h07, 20);
    checks++; if (fd_cnt - fd0 !== 1) begin errors++; $display("FAIL midreset_eight got %0d exp 1", fd_cnt - fd0); end
    checks++; if (digits !== 32'h76543210) begin errors++; $display("FAIL midreset_digits got %h exp 76543210", digits); end
  endtask

  initial begin
    test_reset();
    test_scan_frame();
    test_settle();
    test_dp_err();
    test_hex_blank();
    test_stale();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
